gpio_pcint: RTL

//  Pin-change interrupt unit sitting between the package pins and the GPIO port on the IO bus.
//  - Synchronises raw pins and forwards the clean value (pin_sync) to the GPIO PINx input.
//  - Detects per-pin change, rising, falling or low-level events and latches them in flag bits.
//  - Raises a level interrupt request to the CPU interrupt logic when an enabled, masked flag is pending.

---
 rtl/gpio_pcint_pkg.sv | 32 +++
 rtl/gpio_pcint_if.sv | 14 +
 rtl/gpio_pcint_sync.sv | 48 ++++
 rtl/gpio_pcint.sv | 77 +++++++
 4 files changed

// File: rtl/gpio_pcint_pkg.sv
// Shared types and constants for the pin-change interrupt unit:
// mode encodings, PCCR layout and default IO addresses.
package gpio_pcint_pkg;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned PIN_W  = 8;
   localparam int unsigned ARM_W  = 2;
   localparam int unsigned PCCR_W = 3;

   localparam logic [ARM_W-1:0]  ARM_MAX    = 2'd3;
   localparam logic [ADDR_W-1:0] PCMSK_ADDR = 6'h03;
   localparam logic [ADDR_W-1:0] PCIFR_ADDR = 6'h04;
   localparam logic [ADDR_W-1:0] PCCR_ADDR  = 6'h05;

   localparam int unsigned PCCR_IE      = 0;
   localparam int unsigned PCCR_MODE_LO = 1;

   typedef enum logic [1:0] {
      PC_ANY  = 2'b00,
      PC_RISE = 2'b01,
      PC_FALL = 2'b10,
      PC_LOW  = 2'b11
   } pc_mode_e;

   // Stored PCCR bits: [2:1] mode, [0] interrupt enable
   typedef struct packed {
      pc_mode_e mode;
      logic     ie;
   } pccr_t;

endpackage

// File: rtl/gpio_pcint_if.sv
// IO bus connection between the CPU register file and the pin-change unit.
interface gpio_pcint_if;
   import gpio_pcint_pkg::*;

   logic [ADDR_W-1:0] io_a;
   logic [DATA_W-1:0] io_di;
   logic [DATA_W-1:0] io_do;
   logic              io_re;
   logic              io_we;

   modport master (output io_a, output io_di, output io_re, output io_we, input io_do);
   modport slave  (input io_a, input io_di, input io_re, input io_we, output io_do);

endinterface

// File: rtl/gpio_pcint_sync.sv
// Pin synchroniser with post-reset arming and per-pin event detection.
module gpio_pcint_sync
   import gpio_pcint_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [PIN_W-1:0] i_pin,
   input  pc_mode_e         i_mode,
   output logic [PIN_W-1:0] o_pin_sync,
   output logic [PIN_W-1:0] o_event_c
);

   logic [PIN_W-1:0] r_s1;
   logic [PIN_W-1:0] r_s2;
   logic [PIN_W-1:0] r_s3;
   logic [ARM_W-1:0] r_arm_cnt;
   logic [PIN_W-1:0] w_raw;

   // s3 trails s2 by one cycle so edges are seen on already-clean data
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1      <= '0;
         r_s2      <= '0;
         r_s3      <= '0;
         r_arm_cnt <= '0;
      end else begin
         r_s1 <= i_pin;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (r_arm_cnt != ARM_MAX) r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
   end

   // Suppressed until the chain has refilled, so reset never looks like an edge
   always_comb begin
      w_raw = '0;
      case (i_mode)
         PC_ANY:  w_raw = r_s2 ^ r_s3;
         PC_RISE: w_raw = r_s2 & ~r_s3;
         PC_FALL: w_raw = ~r_s2 & r_s3;
         PC_LOW:  w_raw = ~r_s2;
      endcase
      o_event_c = (r_arm_cnt == ARM_MAX) ? w_raw : '0;
   end

   assign o_pin_sync = r_s2;

endmodule

// File: rtl/gpio_pcint.sv
// Pin-change interrupt unit: PCMSK/PCIFR/PCCR registers on the IO bus,
// flag latching from synchronised pin events and level irq generation.
module gpio_pcint
   import gpio_pcint_pkg::*;
#(
   parameter logic [ADDR_W-1:0] PCMSK_A = PCMSK_ADDR,
   parameter logic [ADDR_W-1:0] PCIFR_A = PCIFR_ADDR,
   parameter logic [ADDR_W-1:0] PCCR_A  = PCCR_ADDR
)(
   input  logic             i_sys_clk,
   input  logic             i_sys_rst_n,
   gpio_pcint_if.slave      io_bus,
   input  logic [PIN_W-1:0] i_pin_in,
   output logic [PIN_W-1:0] o_pin_sync,
   output logic             o_irq,
   input  logic             i_irq_ack
);

   logic [PIN_W-1:0]  r_pcmsk;
   logic [PIN_W-1:0]  r_pcifr;
   pccr_t             r_pccr;
   logic [PIN_W-1:0]  w_event;
   logic [PIN_W-1:0]  w_clr;
   logic [PIN_W-1:0]  w_pcifr_nxt;
   logic [DATA_W-1:0] w_rdata;
   logic              w_sel_msk;
   logic              w_sel_ifr;
   logic              w_sel_ccr;

   gpio_pcint_sync u_sync (
      .i_clk      (i_sys_clk),
      .i_rst_n    (i_sys_rst_n),
      .i_pin      (i_pin_in),
      .i_mode     (r_pccr.mode),
      .o_pin_sync (o_pin_sync),
      .o_event_c  (w_event)
   );

   assign w_sel_msk = (io_bus.io_a == PCMSK_A);
   assign w_sel_ifr = (io_bus.io_a == PCIFR_A);
   assign w_sel_ccr = (io_bus.io_a == PCCR_A);

   // Clears from W1C write and irq_ack merge; a same-cycle event still wins
   always_comb begin
      w_clr = '0;
      if (io_bus.io_we && w_sel_ifr) w_clr = io_bus.io_di;
      if (i_irq_ack)                 w_clr = w_clr | r_pcmsk;
      w_pcifr_nxt = (r_pcifr & ~w_clr) | w_event;
   end

   // Read mux sees pre-update register values
   always_comb begin
      w_rdata = '0;
      if (io_bus.io_re) begin
         if (w_sel_msk)      w_rdata = r_pcmsk;
         else if (w_sel_ifr) w_rdata = r_pcifr;
         else if (w_sel_ccr) w_rdata = DATA_W'(r_pccr);
      end
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_pcmsk      <= '0;
         r_pcifr      <= '0;
         r_pccr       <= '0;
         io_bus.io_do <= '0;
      end else begin
         r_pcifr      <= w_pcifr_nxt;
         io_bus.io_do <= w_rdata;
         if (io_bus.io_we && w_sel_msk) r_pcmsk <= io_bus.io_di;
         if (io_bus.io_we && w_sel_ccr) r_pccr  <= pccr_t'(io_bus.io_di[PCCR_W-1:0]);
      end
   end

   assign o_irq = r_pccr.ie & (|(r_pcifr & r_pcmsk));

endmodule
